// File: rtl/cp0_reg.sv
// CP0 register file: Count/Compare timer, Status, Cause, EPC,
// constant Config/PRId, WB-stage writes and mfc0 read mux.
module cp0_reg #(
  parameter logic [31:0] STATUS_RST = 32'h1000_0000,
  parameter logic [31:0] CONFIG_VAL = 32'h0000_8000,
  parameter logic [31:0] PRID_VAL   = 32'h0048_0102
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [4:0]  raddr_i,
  input  logic [31:0] data_i,
  input  logic [5:0]  int_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  localparam logic [4:0] A_COUNT   = 5'd9;
  localparam logic [4:0] A_COMPARE = 5'd11;
  localparam logic [4:0] A_STATUS  = 5'd12;
  localparam logic [4:0] A_CAUSE   = 5'd13;
  localparam logic [4:0] A_EPC     = 5'd14;
  localparam logic [4:0] A_PRID    = 5'd15;
  localparam logic [4:0] A_CONFIG  = 5'd16;

  logic       wr_count;
  logic       wr_compare;
  logic       wr_status;
  logic       wr_cause;
  logic       wr_epc;
  logic       match;
  logic [1:0] cause_ivwp;
  logic [1:0] cause_ip_sw;
  logic [5:0] cause_ip_hw;

  assign wr_count   = we_i && (waddr_i == A_COUNT);
  assign wr_compare = we_i && (waddr_i == A_COMPARE);
  assign wr_status  = we_i && (waddr_i == A_STATUS);
  assign wr_cause   = we_i && (waddr_i == A_CAUSE);
  assign wr_epc     = we_i && (waddr_i == A_EPC);

  assign match = (compare_o != 32'h0) && (count_o == compare_o);

  assign cause_o = {8'h00, cause_ivwp, 6'h00,
                    cause_ip_hw, cause_ip_sw, 8'h00};

  assign config_o = CONFIG_VAL;
  assign prid_o   = PRID_VAL;

  // Count increments every cycle unless loaded by mtc0
  always_ff @(posedge clk) begin
    if (rst)
      count_o <= 32'h0;
    else if (wr_count)
      count_o <= data_i;
    else
      count_o <= count_o + 32'd1;
  end

  // Compare load; timer irq is sticky until Compare is rewritten
  always_ff @(posedge clk) begin
    if (rst) begin
      compare_o   <= 32'h0;
      timer_int_o <= 1'b0;
    end else if (wr_compare) begin
      compare_o   <= data_i;
      timer_int_o <= 1'b0;
    end else if (match) begin
      timer_int_o <= 1'b1;
    end
  end

  // Status and EPC are plain full-width registers
  always_ff @(posedge clk) begin
    if (rst) begin
      status_o <= STATUS_RST;
      epc_o    <= 32'h0;
    end else begin
      if (wr_status) status_o <= data_i;
      if (wr_epc)    epc_o    <= data_i;
    end
  end

  // Cause: hw IP sampled each cycle, only IV/WP/IP[1:0] writable
  always_ff @(posedge clk) begin
    if (rst) begin
      cause_ivwp  <= 2'b00;
      cause_ip_sw <= 2'b00;
      cause_ip_hw <= 6'h00;
    end else begin
      cause_ip_hw <= int_i;
      if (wr_cause) begin
        cause_ivwp  <= data_i[23:22];
        cause_ip_sw <= data_i[9:8];
      end
    end
  end

  // mfc0 read mux, no bypass of same-cycle writes
  always_comb begin
    data_o = 32'h0;
    unique case (raddr_i)
      A_COUNT:   data_o = count_o;
      A_COMPARE: data_o = compare_o;
      A_STATUS:  data_o = status_o;
      A_CAUSE:   data_o = cause_o;
      A_EPC:     data_o = epc_o;
      A_PRID:    data_o = PRID_VAL;
      A_CONFIG:  data_o = CONFIG_VAL;
      default:   data_o = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cp0_reg.sv
// Bench for cp0_reg: directed scenarios plus random traffic
// against an architectural model of the CP0 registers.
module tb_cp0_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [4:0]  raddr_i;
  logic [31:0] data_i;
  logic [5:0]  int_i;
  logic [31:0] data_o;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] config_o;
  logic [31:0] prid_o;
  logic        timer_int_o;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
  logic        m_tint;

  localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;

  cp0_reg dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i),
    .raddr_i(raddr_i), .data_i(data_i), .int_i(int_i),
    .data_o(data_o), .count_o(count_o), .compare_o(compare_o),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .config_o(config_o), .prid_o(prid_o),
    .timer_int_o(timer_int_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h0048_0102;
      5'd16:   return 32'h0000_8000;
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge; the model computes the architectural next state
  task automatic tick();
    logic [31:0] nc, ncmp, ns, ncause, ne;
    logic        nt;
    @(posedge clk);
    if (rst) begin
      nc = 0; ncmp = 0; ns = 32'h1000_0000;
      ncause = 0; ne = 0; nt = 0;
    end else begin
      nc = m_count + 1;
      ncmp = m_compare;
      ns = m_status;
      ne = m_epc;
      nt = m_tint || (m_compare != 0 && m_count == m_compare);
      ncause = (m_cause & CAUSE_WMASK) | (32'(int_i) << 10);
      if (we_i) begin
        case (waddr_i)
          5'd9:  nc = data_i;
          5'd11: begin ncmp = data_i; nt = 0; end
          5'd12: ns = data_i;
          5'd13: ncause = (ncause & ~CAUSE_WMASK)
                          | (data_i & CAUSE_WMASK);
          5'd14: ne = data_i;
          default: ;
        endcase
      end
    end
    m_count = nc; m_compare = ncmp; m_status = ns;
    m_cause = ncause; m_epc = ne; m_tint = nt;
    #1;
  endtask

  task automatic idle();
    rst = 0; we_i = 0; waddr_i = 0; data_i = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    rst = 0; we_i = 1; waddr_i = a; data_i = d;
    tick();
    we_i = 0;
  endtask

  task automatic test_reset();
    rst = 1; we_i = 1; waddr_i = 9; data_i = 32'h55;
    int_i = 6'h3f; raddr_i = 15;
    tick();
    tick();
    #1;
    checks++;
    if (status_o !== 32'h1000_0000) begin
      failures++;
      $display("FAIL reset_status got=%h exp=%h", status_o, 32'h1000_0000);
    end
    checks++;
    if (count_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_count got=%h exp=0", count_o);
    end
    checks++;
    if (timer_int_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_timer got=%b exp=0", timer_int_o);
    end
    checks++;
    if (data_o !== 32'h0048_0102) begin
      failures++;
      $display("FAIL reset_prid_read got=%h exp=00480102", data_o);
    end
    checks++;
    if (cause_o !== 32'h0 || epc_o !== 32'h0 || compare_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_other cause=%h epc=%h cmp=%h exp=0",
               cause_o, epc_o, compare_o);
    end
    int_i = 0;
    idle();
  endtask

  task automatic test_count_wrap();
    logic [31:0] exp [3];
    exp[0] = 32'hFFFF_FFFE;
    exp[1] = 32'hFFFF_FFFF;
    exp[2] = 32'h0000_0000;
    wr(9, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (count_o !== exp[i]) begin
        failures++;
        $display("FAIL count_wrap[%0d] got=%h exp=%h", i, count_o, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_timer();
    int n = 0;
    wr(11, 32'd20);
    wr(9, 32'd10);
    while (count_o != 32'd20 && n < 40) begin
      checks++;
      if (timer_int_o !== 1'b0) begin
        failures++;
        $display("FAIL timer_early count=%h got=%b exp=0", count_o, timer_int_o);
      end
      tick();
      n++;
    end
    checks++;
    if (n != 10 || timer_int_o !== 1'b0) begin
      failures++;
      $display("FAIL timer_reach steps=%0d exp=10 irq=%b", n, timer_int_o);
    end
    tick();
    checks++;
    if (timer_int_o !== 1'b1) begin
      failures++;
      $display("FAIL timer_rise got=%b exp=1", timer_int_o);
    end
    wr(9, 32'hFFFF_FFFF);
    tick();
    tick();
    checks++;
    if (timer_int_o !== 1'b1 || count_o !== 32'd1) begin
      failures++;
      $display("FAIL timer_sticky irq=%b count=%h exp=1/1",
               timer_int_o, count_o);
    end
    wr(11, 32'd100);
    checks++;
    if (timer_int_o !== 1'b0) begin
      failures++;
      $display("FAIL timer_clear got=%b exp=0", timer_int_o);
    end
  endtask

  task automatic test_collision();
    wr(9, 32'd100);
    checks++;
    if (count_o !== compare_o) begin
      failures++;
      $display("FAIL coll_setup count=%h cmp=%h", count_o, compare_o);
    end
    wr(11, 32'd500);
    checks++;
    if (timer_int_o !== 1'b0 || compare_o !== 32'd500) begin
      failures++;
      $display("FAIL collision irq=%b cmp=%h exp=0/1f4",
               timer_int_o, compare_o);
    end
    tick();
    checks++;
    if (timer_int_o !== 1'b0) begin
      failures++;
      $display("FAIL collision_after got=%b exp=0", timer_int_o);
    end
  endtask

  task automatic test_cause_mask();
    int_i = 6'b101010;
    wr(13, 32'hFFFF_FFFF);
    checks++;
    if (cause_o !== 32'h00C0_AB00) begin
      failures++;
      $display("FAIL cause_mask got=%h exp=00c0ab00", cause_o);
    end
    int_i = 6'b010101;
    wr(13, 32'h0000_0100);
    checks++;
    if (cause_o !== 32'h0000_5500) begin
      failures++;
      $display("FAIL cause_write_ip got=%h exp=00005500", cause_o);
    end
    int_i = 0;
    tick();
    checks++;
    if (cause_o !== 32'h0000_0100) begin
      failures++;
      $display("FAIL cause_no_latch got=%h exp=00000100", cause_o);
    end
  endtask

  task automatic test_read_mux();
    wr(16, 32'h1234);
    wr(15, 32'h5678);
    wr(7, 32'h5);
    raddr_i = 7;
    #1;
    checks++;
    if (config_o !== 32'h0000_8000 || data_o !== 32'h0) begin
      failures++;
      $display("FAIL ro_ignore cfg=%h rd7=%h exp=8000/0", config_o, data_o);
    end
    raddr_i = 16;
    #1;
    checks++;
    if (data_o !== 32'h0000_8000 || prid_o !== 32'h0048_0102) begin
      failures++;
      $display("FAIL cfg_read rd=%h prid=%h", data_o, prid_o);
    end
    wr(14, 32'hAAAA_0001);
    raddr_i = 14;
    we_i = 1; waddr_i = 14; data_i = 32'h5555_0002;
    #1;
    checks++;
    if (data_o !== 32'hAAAA_0001) begin
      failures++;
      $display("FAIL rd_old_epc got=%h exp=aaaa0001", data_o);
    end
    tick();
    we_i = 0;
    #1;
    checks++;
    if (data_o !== 32'h5555_0002) begin
      failures++;
      $display("FAIL rd_new_epc got=%h exp=55550002", data_o);
    end
  endtask

  task automatic test_random();
    logic [4:0] addrs [10];
    addrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14,
              5'd15, 5'd16, 5'd0, 5'd7, 5'd31};
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(99) == 0);
      we_i = ($urandom_range(2) == 0);
      waddr_i = addrs[$urandom_range(9)];
      raddr_i = ($urandom_range(3) == 0) ? 5'($urandom)
                                          : addrs[$urandom_range(9)];
      int_i = 6'($urandom);
      case ($urandom_range(3))
        0: data_i = m_compare - 32'($urandom_range(4));
        1: data_i = 32'($urandom_range(3));
        default: data_i = $urandom;
      endcase
      #1;
      checks++;
      if (data_o !== m_read(raddr_i)) begin
        failures++;
        $display("FAIL rnd_read[%0d] a=%0d got=%h exp=%h",
                 i, raddr_i, data_o, m_read(raddr_i));
      end
      tick();
      checks++;
      if (count_o !== m_count || compare_o !== m_compare ||
          status_o !== m_status || cause_o !== m_cause ||
          epc_o !== m_epc || timer_int_o !== m_tint) begin
        failures++;
        $display("FAIL rnd_state[%0d] got=%h/%h/%h/%h/%h/%b exp=%h/%h/%h/%h/%h/%b",
                 i, count_o, compare_o, status_o, cause_o, epc_o,
                 timer_int_o, m_count, m_compare, m_status, m_cause,
                 m_epc, m_tint);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    raddr_i = 0;
    int_i = 0;
    test_reset();
    test_count_wrap();
    test_timer();
    test_collision();
    test_cause_mask();
    test_read_mux();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
